// File: rtl/program_loader.sv
// Boot loader: takes a little-endian, length-prefixed byte stream, writes it word by word
// into processor memory, and holds the core in reset until the whole program is in place.
module program_loader #(
  parameter int MAX_WORDS = 1024,
  parameter int ADDR_W    = 32
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  localparam int IDX_W = $clog2(MAX_WORDS) + 1;

  localparam logic [2:0] S_HDR   = 3'd0;
  localparam logic [2:0] S_DATA  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  logic [2:0]        r_state;
  logic [1:0]        r_byteCnt;
  logic [31:0]       r_shift;
  logic [31:0]       r_len;
  logic [IDX_W-1:0]  r_idx;
  logic              r_memWe;
  logic [ADDR_W-1:0] r_memAddr;
  logic [31:0]       r_memDin;
  logic              r_cpuRst;
  logic              r_done;
  logic              r_err;

  logic              w_accept;
  logic [31:0]       w_word;
  logic              w_lastWord;

  assign in_ready   = (r_state == S_HDR) || (r_state == S_DATA);
  assign w_accept   = in_valid && in_ready;
  // Bytes shift in from the top so the first byte of a group ends up in bits 7:0.
  assign w_word     = {in_data, r_shift[31:8]};
  assign w_lastWord = (32'(r_idx) == (r_len - 32'd1));

  assign mem_we   = r_memWe;
  assign mem_addr = r_memAddr;
  assign mem_din  = r_memDin;
  assign cpu_rst  = r_cpuRst;
  assign done     = r_done;
  assign err      = r_err;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_HDR;
      r_byteCnt <= 2'd0;
      r_shift   <= 32'd0;
      r_len     <= 32'd0;
      r_idx     <= '0;
      r_memWe   <= 1'b0;
      r_memAddr <= '0;
      r_memDin  <= 32'd0;
      r_cpuRst  <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_memWe <= 1'b0;
      case (r_state)
        S_HDR: begin
          if (w_accept) begin
            r_shift   <= w_word;
            r_byteCnt <= r_byteCnt + 2'd1;
            if (r_byteCnt == 2'd3) begin
              r_len <= w_word;
              r_idx <= '0;
              // Full 32-bit compare so huge lengths cannot alias onto legal ones.
              if (w_word > 32'(MAX_WORDS)) begin
                r_state <= S_ERR;
                r_err   <= 1'b1;
              end else if (w_word == 32'd0) begin
                r_state  <= S_DONE;
                r_done   <= 1'b1;
                r_cpuRst <= 1'b0;
              end else begin
                r_state <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_shift   <= w_word;
            r_byteCnt <= r_byteCnt + 2'd1;
            if (r_byteCnt == 2'd3) begin
              r_state   <= S_WRITE;
              r_memWe   <= 1'b1;
              r_memAddr <= ADDR_W'(r_idx);
              r_memDin  <= w_word;
            end
          end
        end
        S_WRITE: begin
          if (w_lastWord) begin
            r_state  <= S_DONE;
            r_done   <= 1'b1;
            r_cpuRst <= 1'b0;
          end else begin
            r_idx   <= r_idx + IDX_W'(1);
            r_state <= S_DATA;
          end
        end
        S_DONE, S_ERR: begin
          if (start) begin
            r_state   <= S_HDR;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_idx     <= '0;
            r_byteCnt <= 2'd0;
            r_cpuRst  <= 1'b1;
          end
        end
        default: r_state <= S_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: a table of whole-load vectors plus
// hand-written sequences for stalls, restarts and mid-load resets.
module tb_program_loader;

  localparam int MAX_WORDS = 1024;
  localparam int ADDR_W    = 32;

  logic              clock    = 1'b0;
  logic              rst_n    = 1'b1;
  logic              start    = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data  = 8'd0;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic              cpu_rst;
  logic              done;
  logic              err;

  program_loader #(.MAX_WORDS(MAX_WORDS), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .cpu_rst(cpu_rst), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  int          checks     = 0;
  int          failures   = 0;
  int          writeCount = 0;
  logic [31:0] lastAddr   = 32'd0;
  logic        prevWe     = 1'b0;
  logic [31:0] dutMem [0:MAX_WORDS-1];
  logic [31:0] expMem [0:MAX_WORDS-1];

  typedef struct {
    string       name;
    logic [31:0] len;
    logic        expDone;
    logic        expErr;
    int          expWrites;
  } vec_t;

  vec_t vecs [8];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Write monitor: captures every strobe into a shadow memory and checks strobe shape.
  always @(negedge clock) begin
    if (rst_n && mem_we) begin
      checkOutput("we_single_cycle", 64'(prevWe), 64'd0);
      checkOutput("ready_low_in_write", 64'(in_ready), 64'd0);
      checkOutput("cpu_rst_in_write", 64'(cpu_rst), 64'd1);
      checkOutput("write_addr_order", 64'(mem_addr), 64'(writeCount));
      if (mem_addr < 32'(MAX_WORDS)) dutMem[mem_addr[9:0]] = mem_din;
      lastAddr = mem_addr;
      writeCount++;
    end
    prevWe = mem_we;
  end

  task automatic clearCapture();
    writeCount = 0;
    for (int i = 0; i < MAX_WORDS; i++) dutMem[i] = 32'hBAD0_BAD0;
  endtask

  task automatic doReset();
    in_valid = 1'b0;
    start    = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    rst_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 100) checkOutput("byte_accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w);
    for (int k = 0; k < 4; k++) sendByte(w[8*k +: 8]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic waitSettle(input string name);
    int g = 0;
    while (!(done || err) && g < 50) begin
      @(posedge clock);
      #1;
      g++;
    end
    checkOutput(name, 64'(done | err), 64'd1);
  endtask

  task automatic compareMem(input string name, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) if (dutMem[i] !== expMem[i]) bad++;
    checkOutput(name, 64'(bad), 64'd0);
  endtask

  // One whole load from reset: header, then the expected number of data words.
  task automatic applyStimulus(input vec_t v);
    logic [31:0] w;
    doReset();
    clearCapture();
    sendWord(v.len);
    for (int i = 0; i < v.expWrites; i++) begin
      w = v.len ^ (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
      expMem[i] = w;
      sendWord(w);
    end
    waitSettle({v.name, "_settled"});
    idle(2);
    checkOutput({v.name, "_done"}, 64'(done), 64'(v.expDone));
    checkOutput({v.name, "_err"}, 64'(err), 64'(v.expErr));
    checkOutput({v.name, "_cpu_rst"}, 64'(cpu_rst), 64'(!v.expDone));
    checkOutput({v.name, "_in_ready"}, 64'(in_ready), 64'd0);
    checkOutput({v.name, "_writes"}, 64'(writeCount), 64'(v.expWrites));
    compareMem({v.name, "_mem"}, v.expWrites);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{"n0",        32'd0,          1'b1, 1'b0, 0};
    vecs[1] = '{"n1",        32'd1,          1'b1, 1'b0, 1};
    vecs[2] = '{"n2",        32'd2,          1'b1, 1'b0, 2};
    vecs[3] = '{"n5",        32'd5,          1'b1, 1'b0, 5};
    vecs[4] = '{"n1025",     32'd1025,       1'b0, 1'b1, 0};
    vecs[5] = '{"n10000",    32'h0001_0000,  1'b0, 1'b1, 0};
    vecs[6] = '{"n01000400", 32'h0100_0400,  1'b0, 1'b1, 0};
    vecs[7] = '{"nFFFFFFFF", 32'hFFFF_FFFF,  1'b0, 1'b1, 0};

    // Reset values, sampled while reset is held.
    clearCapture();
    #2;
    rst_n = 1'b0;
    #3;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_cpu_rst", 64'(cpu_rst), 64'd1);
    checkOutput("rst_mem_we", 64'(mem_we), 64'd0);
    checkOutput("rst_mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("rst_mem_din", 64'(mem_din), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_err", 64'(err), 64'd0);

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    // Three back-to-back words; address/data must hold after the last strobe.
    doReset();
    clearCapture();
    expMem[0] = 32'h0000_0001;
    expMem[1] = 32'h0000_0002;
    expMem[2] = 32'hFFFF_FFFF;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] hdr;
      hdr = 32'd3;
      sendByte(hdr[8*k +: 8]);
    end
    for (int i = 0; i < 3; i++) sendWord(expMem[i]);
    waitSettle("three_settled");
    idle(3);
    checkOutput("three_writes", 64'(writeCount), 64'd3);
    compareMem("three_mem", 3);
    checkOutput("three_done", 64'(done), 64'd1);
    checkOutput("three_cpu_rst", 64'(cpu_rst), 64'd0);
    checkOutput("three_addr_hold", 64'(mem_addr), 64'd2);
    checkOutput("three_din_hold", 64'(mem_din), 64'hFFFF_FFFF);

    // Restart from DONE without reset; then a stalled byte stream with a start pulse mid-DATA.
    pulseStart();
    checkOutput("restart_done_clr", 64'(done), 64'd0);
    checkOutput("restart_cpu_rst", 64'(cpu_rst), 64'd1);
    checkOutput("restart_in_ready", 64'(in_ready), 64'd1);
    clearCapture();
    sendWord(32'd1);
    sendByte(8'h78);
    idle(5);
    sendByte(8'h56);
    idle(2);
    pulseStart();
    idle(2);
    sendByte(8'h34);
    idle(5);
    sendByte(8'h12);
    waitSettle("stall_settled");
    checkOutput("stall_writes", 64'(writeCount), 64'd1);
    checkOutput("stall_addr", 64'(lastAddr), 64'd0);
    checkOutput("stall_data", 64'(dutMem[0]), 64'h1234_5678);
    checkOutput("stall_done", 64'(done), 64'd1);

    // Zero-length header: DONE with core released on the very next cycle.
    doReset();
    clearCapture();
    sendByte(8'h00);
    sendByte(8'h00);
    sendByte(8'h00);
    checkOutput("zero_cpu_rst_before", 64'(cpu_rst), 64'd1);
    sendByte(8'h00);
    checkOutput("zero_done_next", 64'(done), 64'd1);
    checkOutput("zero_cpu_rst_next", 64'(cpu_rst), 64'd0);
    idle(3);
    checkOutput("zero_writes", 64'(writeCount), 64'd0);

    // Oversize header, then recovery with start.
    doReset();
    clearCapture();
    sendWord(32'd1025);
    idle(3);
    checkOutput("over_err", 64'(err), 64'd1);
    checkOutput("over_cpu_rst", 64'(cpu_rst), 64'd1);
    checkOutput("over_in_ready", 64'(in_ready), 64'd0);
    checkOutput("over_writes", 64'(writeCount), 64'd0);
    pulseStart();
    checkOutput("over_restart_err", 64'(err), 64'd0);
    checkOutput("over_restart_ready", 64'(in_ready), 64'd1);
    checkOutput("over_restart_cpu_rst", 64'(cpu_rst), 64'd1);

    // Reset part way through word 1, then reset while a write strobe is up.
    doReset();
    clearCapture();
    sendWord(32'd2);
    sendWord(32'h1111_1111);
    sendByte(8'hAA);
    sendByte(8'hBB);
    rst_n = 1'b0;
    #2;
    checkOutput("midrst_mem_we", 64'(mem_we), 64'd0);
    checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clock);
    rst_n = 1'b1;
    idle(10);
    checkOutput("midrst_writes", 64'(writeCount), 64'd1);
    checkOutput("midrst_done", 64'(done), 64'd0);
    clearCapture();
    sendWord(32'd1);
    sendWord(32'hCAFE_F00D);
    checkOutput("wrrst_we_up", 64'(mem_we), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("wrrst_we_cleared", 64'(mem_we), 64'd0);
    checkOutput("wrrst_din_cleared", 64'(mem_din), 64'd0);
    @(negedge clock);
    rst_n = 1'b1;
    idle(3);
    checkOutput("wrrst_writes", 64'(writeCount), 64'd0);
    sendWord(32'd1);
    sendWord(32'hDEAD_BEEF);
    waitSettle("reload_settled");
    checkOutput("reload_writes", 64'(writeCount), 64'd1);
    checkOutput("reload_addr", 64'(lastAddr), 64'd0);
    checkOutput("reload_data", 64'(dutMem[0]), 64'hDEAD_BEEF);

    // Maximum length with random data.
    doReset();
    clearCapture();
    sendWord(32'd1024);
    for (int i = 0; i < MAX_WORDS; i++) begin
      expMem[i] = $urandom;
      sendWord(expMem[i]);
    end
    waitSettle("max_settled");
    checkOutput("max_writes", 64'(writeCount), 64'd1024);
    checkOutput("max_last_addr", 64'(lastAddr), 64'd1023);
    checkOutput("max_done", 64'(done), 64'd1);
    checkOutput("max_cpu_rst", 64'(cpu_rst), 64'd0);
    compareMem("max_mem", MAX_WORDS);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
